// File: rtl/conv2d_engine.sv
// ============================================================================
// conv2d_engine
// ----------------------------------------------------------------------------
// Memory-mapped 2D convolution accelerator. Acts as a burst master on a
// ready/valid memory interface (read-address, read-data, write-address,
// write-data). Computes a same-size output feature map from a square N x N
// input feature map and a WT_DIM x WT_DIM kernel with zero padding. Products
// and sums are unsigned and wrap modulo 2^DWIDTH.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   start / idle / done      run control; done is a level held until the
//                            next accepted start or reset
//   fm_dim                   feature-map side length N (0 -> straight to done)
//   wt/ifm/ofm_offset        word base addresses of kernel, IFM and OFM
//   req_read_addr*/len       read burst request channel
//   resp_read_data*          read data channel
//   req_write_addr*/len      write address channel (len always 1)
//   req_write_data*          write data channel (one word per output pixel)
//   resp_write_status*       unused write response channel (tied off)
//
// Optional build macro:
//   CONV2D_CYCLE_COUNT_EN    adds output cycle_count[31:0]: cleared on an
//                            accepted start, counts every busy cycle, holds
//                            while idle.
// ============================================================================
module conv2d_engine #(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32,
    parameter int WT_DIM = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              idle,
    output logic              done,
    input  logic [31:0]       fm_dim,
    input  logic [31:0]       wt_offset,
    input  logic [31:0]       ifm_offset,
    input  logic [31:0]       ofm_offset,
    output logic [AWIDTH-1:0] req_read_addr,
    output logic              req_read_addr_valid,
    input  logic              req_read_addr_ready,
    output logic [31:0]       req_read_len,
    input  logic [DWIDTH-1:0] resp_read_data,
    input  logic              resp_read_data_valid,
    output logic              resp_read_data_ready,
    output logic [AWIDTH-1:0] req_write_addr,
    output logic              req_write_addr_valid,
    input  logic              req_write_addr_ready,
    output logic [31:0]       req_write_len,
    output logic [DWIDTH-1:0] req_write_data,
    output logic              req_write_data_valid,
    input  logic              req_write_data_ready,
    output logic              resp_write_status,
    output logic              resp_write_status_valid,
    input  logic              resp_write_status_ready
`ifdef CONV2D_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    localparam int unsigned LP_K  = WT_DIM * WT_DIM;
    localparam int          LP_KW = $clog2(LP_K + 1);
    localparam int          LP_MW = $clog2(WT_DIM + 1);
    localparam logic signed [33:0] LP_H = 34'(WT_DIM / 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WT_ADDR = 3'd1;
    localparam logic [2:0] S_WT_DATA = 3'd2;
    localparam logic [2:0] S_ROW     = 3'd3;
    localparam logic [2:0] S_RD_ADDR = 3'd4;
    localparam logic [2:0] S_RD_DATA = 3'd5;
    localparam logic [2:0] S_WR      = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]        r_state;
    logic              r_done;
    logic [31:0]       r_n;
    logic [AWIDTH-1:0] r_ifm_off;
    logic [AWIDTH-1:0] r_ofm_off;
    logic [31:0]       r_x;
    logic [31:0]       r_y;
    logic [LP_MW-1:0]  r_m;
    logic [LP_KW-1:0]  r_widx;
    logic [31:0]       r_beats;
    logic [DWIDTH-1:0] r_acc;
    logic [DWIDTH-1:0] r_wt [LP_K];

    logic [AWIDTH-1:0] r_ar_addr;
    logic              r_ar_valid;
    logic [31:0]       r_ar_len;
    logic              r_rready;
    logic [AWIDTH-1:0] r_aw_addr;
    logic              r_aw_valid;
    logic [DWIDTH-1:0] r_w_data;
    logic              r_w_valid;

    // Per-row window geometry, all in signed 34-bit so halo arithmetic
    // around row/column 0 and N-1 never wraps.
    logic signed [33:0] w_row;
    logic signed [33:0] w_xl;
    logic signed [33:0] w_xh;
    logic signed [33:0] w_nlast;
    logic signed [33:0] w_c0;
    logic signed [33:0] w_c1;
    logic signed [33:0] w_len;
    logic signed [33:0] w_n0;
    logic               w_row_ok;
    logic [LP_KW-1:0]   w_widx0;
    logic [AWIDTH-1:0]  w_rd_addr;
    logic [AWIDTH-1:0]  w_wr_addr;
    logic [DWIDTH-1:0]  w_prod;
    logic               w_beat;
    logic               w_aw_ok;
    logic               w_w_ok;
    logic               w_last_x;
    logic               w_last_y;
    logic               w_idle;
    logic               w_unused;

    assign w_row    = $signed({2'b00, r_y}) - LP_H + $signed(34'(r_m));
    assign w_xl     = $signed({2'b00, r_x}) - LP_H;
    assign w_xh     = $signed({2'b00, r_x}) + LP_H;
    assign w_nlast  = $signed({2'b00, r_n}) - 34'sd1;
    assign w_row_ok = (w_row >= 34'sd0) && (w_row <= w_nlast);
    assign w_c0     = (w_xl < 34'sd0) ? '0 : w_xl;
    assign w_c1     = (w_xh > w_nlast) ? w_nlast : w_xh;
    assign w_len    = w_c1 - w_c0 + 34'sd1;
    // First kernel column that lines up with the clipped window start.
    assign w_n0     = w_c0 - w_xl;
    assign w_widx0  = LP_KW'(r_m) * LP_KW'(WT_DIM) + LP_KW'(w_n0);

    assign w_rd_addr = r_ifm_off + AWIDTH'(w_row) * AWIDTH'(r_n) + AWIDTH'(w_c0);
    assign w_wr_addr = r_ofm_off + AWIDTH'(r_y) * AWIDTH'(r_n) + AWIDTH'(r_x);

    assign w_prod   = resp_read_data * r_wt[r_widx];
    assign w_beat   = resp_read_data_valid && r_rready;
    assign w_aw_ok  = !r_aw_valid || req_write_addr_ready;
    assign w_w_ok   = !r_w_valid || req_write_data_ready;
    assign w_last_x = (r_x == r_n - 32'd1);
    assign w_last_y = (r_y == r_n - 32'd1);
    assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE);

    assign w_unused = ^{resp_write_status_ready, w_n0[33:LP_KW], w_len[33:32], w_row[33:AWIDTH]};

    assign idle                    = w_idle;
    assign done                    = r_done;
    assign req_read_addr           = r_ar_addr;
    assign req_read_addr_valid     = r_ar_valid;
    assign req_read_len            = r_ar_len;
    assign resp_read_data_ready    = r_rready;
    assign req_write_addr          = r_aw_addr;
    assign req_write_addr_valid    = r_aw_valid;
    assign req_write_len           = 32'd1;
    assign req_write_data          = r_w_data;
    assign req_write_data_valid    = r_w_valid;
    assign resp_write_status       = 1'b0;
    assign resp_write_status_valid = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_n        <= '0;
            r_ifm_off  <= '0;
            r_ofm_off  <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_m        <= '0;
            r_widx     <= '0;
            r_beats    <= '0;
            r_acc      <= '0;
            for (int unsigned i = 0; i < LP_K; i++) begin
                r_wt[i] <= '0;
            end
            r_ar_addr  <= '0;
            r_ar_valid <= 1'b0;
            r_ar_len   <= '0;
            r_rready   <= 1'b0;
            r_aw_addr  <= '0;
            r_aw_valid <= 1'b0;
            r_w_data   <= '0;
            r_w_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_n       <= fm_dim;
                        r_ifm_off <= AWIDTH'(ifm_offset);
                        r_ofm_off <= AWIDTH'(ofm_offset);
                        r_done    <= 1'b0;
                        if (fm_dim == 32'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_ar_addr  <= AWIDTH'(wt_offset);
                            r_ar_len   <= 32'(LP_K);
                            r_ar_valid <= 1'b1;
                            r_state    <= S_WT_ADDR;
                        end
                    end else if (r_state == S_DONE) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WT_ADDR: begin
                    if (req_read_addr_ready) begin
                        r_ar_valid <= 1'b0;
                        r_rready   <= 1'b1;
                        r_beats    <= r_ar_len;
                        r_widx     <= '0;
                        r_state    <= S_WT_DATA;
                    end
                end
                S_WT_DATA: begin
                    if (w_beat) begin
                        r_wt[r_widx] <= resp_read_data;
                        r_widx       <= r_widx + LP_KW'(1);
                        r_beats      <= r_beats - 32'd1;
                        if (r_beats == 32'd1) begin
                            r_rready <= 1'b0;
                            r_x      <= '0;
                            r_y      <= '0;
                            r_m      <= '0;
                            r_acc    <= '0;
                            r_state  <= S_ROW;
                        end
                    end
                end
                S_ROW: begin
                    // One kernel row per visit; rows falling in the padding
                    // contribute zero and are skipped without a request.
                    if (r_m == LP_MW'(WT_DIM)) begin
                        r_aw_addr  <= w_wr_addr;
                        r_aw_valid <= 1'b1;
                        r_w_data   <= r_acc;
                        r_w_valid  <= 1'b1;
                        r_state    <= S_WR;
                    end else if (w_row_ok) begin
                        r_ar_addr  <= w_rd_addr;
                        r_ar_len   <= 32'(w_len);
                        r_ar_valid <= 1'b1;
                        r_widx     <= w_widx0;
                        r_state    <= S_RD_ADDR;
                    end else begin
                        r_m <= r_m + LP_MW'(1);
                    end
                end
                S_RD_ADDR: begin
                    if (req_read_addr_ready) begin
                        r_ar_valid <= 1'b0;
                        r_rready   <= 1'b1;
                        r_beats    <= r_ar_len;
                        r_state    <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_beat) begin
                        r_acc   <= r_acc + w_prod;
                        r_widx  <= r_widx + LP_KW'(1);
                        r_beats <= r_beats - 32'd1;
                        if (r_beats == 32'd1) begin
                            r_rready <= 1'b0;
                            r_m      <= r_m + LP_MW'(1);
                            r_state  <= S_ROW;
                        end
                    end
                end
                S_WR: begin
                    // Address and data channels retire independently; the
                    // pixel advances once both have been accepted.
                    if (r_aw_valid && req_write_addr_ready) begin
                        r_aw_valid <= 1'b0;
                    end
                    if (r_w_valid && req_write_data_ready) begin
                        r_w_valid <= 1'b0;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_acc <= '0;
                        r_m   <= '0;
                        if (w_last_x) begin
                            r_x <= '0;
                            if (w_last_y) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_y     <= r_y + 32'd1;
                                r_state <= S_ROW;
                            end
                        end else begin
                            r_x     <= r_x + 32'd1;
                            r_state <= S_ROW;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV2D_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_count <= '0;
        end else if (w_idle && start) begin
            r_cycle_count <= '0;
        end else if (!w_idle) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_conv2d_engine.sv
// ============================================================================
// tb_conv2d_engine
// ----------------------------------------------------------------------------
// Bench for conv2d_engine: a behavioural memory controller with configurable
// read latency and random ready/valid throttling, plus a scoreboard holding
// expected (address, data) pairs pushed when each job is launched and popped
// as write transactions complete.
// ============================================================================
module tb_conv2d_engine;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          idle, done;
    logic [31:0]   fm_dim = '0;
    logic [31:0]   wt_offset = '0, ifm_offset = '0, ofm_offset = '0;
    logic [AW-1:0] req_read_addr;
    logic          req_read_addr_valid;
    logic          ar_rdy = 1'b0;
    logic [31:0]   req_read_len;
    logic [DW-1:0] rd_data = '0;
    logic          rd_valid = 1'b0;
    logic          resp_read_data_ready;
    logic [AW-1:0] req_write_addr;
    logic          req_write_addr_valid;
    logic          aw_rdy = 1'b0;
    logic [31:0]   req_write_len;
    logic [DW-1:0] req_write_data;
    logic          req_write_data_valid;
    logic          w_rdy = 1'b0;
    logic          resp_write_status, resp_write_status_valid;
`ifdef CONV2D_CYCLE_COUNT_EN
    logic [31:0]   cycle_count;
`endif

    always #5 clk = ~clk;

    conv2d_engine #(.AWIDTH(AW), .DWIDTH(DW), .WT_DIM(3)) dut (
        .clk(clk), .rst(rst), .start(start), .idle(idle), .done(done),
        .fm_dim(fm_dim), .wt_offset(wt_offset), .ifm_offset(ifm_offset),
        .ofm_offset(ofm_offset),
        .req_read_addr(req_read_addr), .req_read_addr_valid(req_read_addr_valid),
        .req_read_addr_ready(ar_rdy), .req_read_len(req_read_len),
        .resp_read_data(rd_data), .resp_read_data_valid(rd_valid),
        .resp_read_data_ready(resp_read_data_ready),
        .req_write_addr(req_write_addr), .req_write_addr_valid(req_write_addr_valid),
        .req_write_addr_ready(aw_rdy), .req_write_len(req_write_len),
        .req_write_data(req_write_data), .req_write_data_valid(req_write_data_valid),
        .req_write_data_ready(w_rdy),
        .resp_write_status(resp_write_status),
        .resp_write_status_valid(resp_write_status_valid),
        .resp_write_status_ready(1'b1)
`ifdef CONV2D_CYCLE_COUNT_EN
        , .cycle_count(cycle_count)
`endif
    );

    logic [31:0] mem [0:MEMSZ-1];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t           exp_q[$];
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 2;
    int rdy_pct  = 100;
    int n_writes = 0;
    int n_bursts = 0;
    int max_ifm_len = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory controller model
    // ------------------------------------------------------------------
    initial begin : ctrl
        logic          s_ar, s_r, s_aw, s_w;
        logic [AW-1:0] s_ar_addr, s_aw_addr;
        logic [31:0]   s_ar_len, s_aw_len, s_wdata;
        logic          p_ar, p_aw, p_w;
        logic [63:0]   p_ar_pl, p_aw_pl, p_w_pl;
        logic          cur_active;
        logic [AW-1:0] cur_addr;
        int            cur_len, cur_idx, cur_wait;
        p_ar = 0; p_aw = 0; p_w = 0;
        p_ar_pl = '0; p_aw_pl = '0; p_w_pl = '0;
        cur_active = 0; cur_addr = '0; cur_len = 0; cur_idx = 0; cur_wait = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_valid = 1'b0;
                cur_active = 0;
                p_ar = 0; p_aw = 0; p_w = 0;
                wa_q.delete();
                wd_q.delete();
                continue;
            end
            // Anything stalled last cycle must still be offered unchanged.
            if (p_ar) check("ar_hold", {1'b1, req_read_addr_valid, 2'b0, req_read_addr, req_read_len}, p_ar_pl);
            if (p_aw) check("aw_hold", {1'b1, req_write_addr_valid, 2'b0, req_write_addr, req_write_len}, p_aw_pl);
            if (p_w)  check("w_hold",  {31'b1, req_write_data_valid, req_write_data}, p_w_pl);
            p_ar = req_read_addr_valid && !ar_rdy;
            p_ar_pl = {1'b1, 1'b1, 2'b0, req_read_addr, req_read_len};
            p_aw = req_write_addr_valid && !aw_rdy;
            p_aw_pl = {1'b1, 1'b1, 2'b0, req_write_addr, req_write_len};
            p_w = req_write_data_valid && !w_rdy;
            p_w_pl = {31'b1, 1'b1, req_write_data};

            s_ar = req_read_addr_valid && ar_rdy;
            s_ar_addr = req_read_addr; s_ar_len = req_read_len;
            s_r  = rd_valid && resp_read_data_ready;
            s_aw = req_write_addr_valid && aw_rdy;
            s_aw_addr = req_write_addr; s_aw_len = req_write_len;
            s_w  = req_write_data_valid && w_rdy;
            s_wdata = req_write_data;

            @(posedge clk);
            #1;
            if (rst) continue;
            if (s_r) begin
                rd_valid = 1'b0;
                cur_idx++;
                if (cur_idx >= cur_len) cur_active = 0;
            end
            if (s_ar) begin
                check("ar_single_outstanding", {63'b0, cur_active}, 64'd0);
                n_bursts++;
                if (n_bursts > 1 && int'(s_ar_len) > max_ifm_len) max_ifm_len = int'(s_ar_len);
                cur_active = 1; cur_addr = s_ar_addr; cur_len = int'(s_ar_len);
                cur_idx = 0; cur_wait = lat;
            end
            if (cur_active && cur_wait > 0) cur_wait--;
            if (cur_active && cur_wait == 0 && !rd_valid && ($urandom_range(99) < rdy_pct)) begin
                rd_valid = 1'b1;
                rd_data  = mem[AW'(cur_addr + AW'(cur_idx))];
            end
            if (s_aw) begin
                check("aw_len", {32'b0, s_aw_len}, 64'd1);
                wa_q.push_back(s_aw_addr);
            end
            if (s_w) wd_q.push_back(s_wdata);
            while (wa_q.size() > 0 && wd_q.size() > 0) begin
                logic [AW-1:0] a;
                logic [31:0]   d;
                a = wa_q.pop_front();
                d = wd_q.pop_front();
                mem[a] = d;
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_write", {50'b0, a}, 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("ofm_addr", {50'b0, a}, {50'b0, e.addr});
                    check("ofm_data", {32'b0, d}, {32'b0, e.data});
                end
            end
            ar_rdy = ($urandom_range(99) < rdy_pct);
            aw_rdy = ($urandom_range(99) < rdy_pct);
            w_rdy  = ($urandom_range(99) < rdy_pct);
        end
    end

    // ------------------------------------------------------------------
    // Reference model and job helpers
    // ------------------------------------------------------------------
    task automatic push_model(input int n, input int wo, input int io, input int oo);
        for (int y = 0; y < n; y++) begin
            for (int x = 0; x < n; x++) begin
                logic [31:0] acc;
                wr_t e;
                acc = '0;
                for (int m = 0; m < 3; m++) begin
                    for (int k = 0; k < 3; k++) begin
                        int r, c;
                        r = y - 1 + m;
                        c = x - 1 + k;
                        if (r >= 0 && r < n && c >= 0 && c < n)
                            acc = acc + mem[AW'(io + r * n + c)] * mem[AW'(wo + m * 3 + k)];
                    end
                end
                e.addr = AW'(oo + y * n + x);
                e.data = acc;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_table1(input int oo);
        logic [31:0] row_a [4];
        logic [31:0] row_b [4];
        wr_t e;
        row_a = '{32'd4, 32'd10, 32'd16, 32'd6};
        row_b = '{32'd6, 32'd15, 32'd24, 32'd9};
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                e.addr = AW'(oo + y * 4 + x);
                e.data = (y == 0 || y == 3) ? row_a[x] : row_b[x];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic launch(input int n, input int wo, input int io, input int oo);
        n_writes = 0;
        n_bursts = 0;
        max_ifm_len = 0;
        @(posedge clk);
        #1;
        fm_dim = 32'(n); wt_offset = 32'(wo); ifm_offset = 32'(io); ofm_offset = 32'(oo);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (n != 0) begin
            @(negedge clk);
            check("done_drop_after_start", {62'b0, done, idle}, 64'd0);
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done && idle) begin
                ok = 1;
                break;
            end
        end
        check("done_timeout", {63'b0, ok}, 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic fill_random(input int wo, input int io, input int n);
        for (int i = 0; i < 9; i++) mem[AW'(wo + i)] = $urandom;
        for (int i = 0; i < n * n; i++) mem[AW'(io + i)] = $urandom;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_idle_done", {62'b0, idle, done}, 64'd2);
        check("reset_valids", {60'b0, req_read_addr_valid, resp_read_data_ready,
                               req_write_addr_valid, req_write_data_valid}, 64'd0);
        check("reset_payloads", {req_read_len, 4'b0, req_read_addr, 14'b0}, 64'd0);
        check("reset_wr_payload", {req_write_data, 18'b0, req_write_addr}, 64'd0);
        rst = 1'b0;

        // Test 1: reference job from the plan
        for (int m = 0; m < 3; m++)
            for (int k = 0; k < 3; k++) mem[m * 3 + k] = 32'(k);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) mem[9 + y * 4 + x] = 32'(x);
        push_table1(25);
        launch(4, 0, 9, 25);
        wait_done();
        check("t1_writes", 64'(n_writes), 64'd16);
        check("t1_status", {62'b0, resp_write_status, resp_write_status_valid}, 64'd0);

        // Test 2: rerun without reset
        push_table1(25);
        launch(4, 0, 9, 25);
        wait_done();

        // Test 3: slow, throttled controller
        lat = 10;
        rdy_pct = 60;
        push_table1(25);
        launch(4, 0, 9, 25);
        wait_done();
        check("t3_writes", 64'(n_writes), 64'd16);

        // Test 4: 1x1 feature map
        for (int i = 0; i < 9; i++) mem[100 + i] = 32'd2;
        mem[200] = 32'd7;
        begin
            wr_t e;
            e.addr = AW'(300);
            e.data = 32'd14;
            exp_q.push_back(e);
        end
        launch(1, 100, 200, 300);
        wait_done();
        check("t4_writes", 64'(n_writes), 64'd1);
        check("t4_ifm_burst_len", 64'(max_ifm_len), 64'd1);

        // Test 5: start pulsed mid-run is ignored
        lat = 3;
        rdy_pct = 80;
        fill_random(1000, 1100, 5);
        push_model(5, 1000, 1100, 1200);
        launch(5, 1000, 1100, 1200);
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        check("t5_writes", 64'(n_writes), 64'd25);

        // Test 6: reset mid-run, then a clean rerun
        fill_random(2000, 2100, 5);
        push_model(5, 2000, 2100, 2200);
        launch(5, 2000, 2100, 2200);
        repeat (60) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_idle_done", {62'b0, idle, done}, 64'd2);
        check("midrst_valids", {60'b0, req_read_addr_valid, resp_read_data_ready,
                                req_write_addr_valid, req_write_data_valid}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        push_model(5, 2000, 2100, 2200);
        launch(5, 2000, 2100, 2200);
        wait_done();
        check("t6_writes", 64'(n_writes), 64'd25);

        // Test 7: wrap-around arithmetic
        for (int i = 0; i < 9; i++) mem[400 + i] = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) mem[500 + i] = 32'd2;
        begin
            wr_t e;
            e.addr = AW'(600); e.data = 32'hFFFF_FFF8;   // 4 taps * 2 * (2^32-1)
            exp_q.push_back(e);
            e.addr = AW'(601); e.data = 32'hFFFF_FFF4;   // 6 taps
            exp_q.push_back(e);
            e.addr = AW'(602); e.data = 32'hFFFF_FFF8;
            exp_q.push_back(e);
            e.addr = AW'(603); e.data = 32'hFFFF_FFF4;
            exp_q.push_back(e);
            e.addr = AW'(604); e.data = 32'hFFFF_FFEE;   // 9 taps
            exp_q.push_back(e);
            e.addr = AW'(605); e.data = 32'hFFFF_FFF4;
            exp_q.push_back(e);
            e.addr = AW'(606); e.data = 32'hFFFF_FFF8;
            exp_q.push_back(e);
            e.addr = AW'(607); e.data = 32'hFFFF_FFF4;
            exp_q.push_back(e);
            e.addr = AW'(608); e.data = 32'hFFFF_FFF8;
            exp_q.push_back(e);
        end
        launch(3, 400, 500, 600);
        wait_done();
`ifdef CONV2D_CYCLE_COUNT_EN
        begin
            logic [31:0] cc;
            cc = cycle_count;
            check("cc_nonzero", {63'b0, (cc != 32'd0)}, 64'd1);
            repeat (5) @(negedge clk);
            check("cc_frozen", {32'b0, cycle_count}, {32'b0, cc});
        end
`endif

        // Test 8: empty feature map
        launch(0, 0, 9, 25);
        wait_done();
        check("t8_no_traffic", {32'(n_writes), 32'(n_bursts)}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv2d_engine.md
Name: conv2d_engine

Overview:
- Memory-mapped 2D convolution accelerator; master on a ready/valid burst memory interface (read-address, read-data, write-address, write-data channels) in front of the shared data memory via the IO/dmem controller.
- Computes a same-size output feature map (OFM) from a square input feature map (IFM) and a WT_DIM x WT_DIM kernel, with zero padding.
- All operands are DWIDTH-bit words, row-major, at word addresses given by the offset inputs.

Parameters:
- AWIDTH, 14, word-address width of the memory interface.
- DWIDTH, 32, data word width.
- WT_DIM, 3, kernel side length (odd); halo H = WT_DIM/2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; honoured only while idle.
- idle  out  1  engine in IDLE state.
- done  out  1  run complete (level).
- fm_dim  in  32  IFM/OFM side length N.
- wt_offset / ifm_offset / ofm_offset  in  32 each  word base addresses of kernel, IFM, OFM.
- req_read_addr  out  AWIDTH  burst start word address.
- req_read_addr_valid  out  1; req_read_addr_ready  in  1.
- req_read_len  out  32  burst length in words (>=1).
- resp_read_data  in  DWIDTH; resp_read_data_valid  in  1; resp_read_data_ready  out  1.
- req_write_addr  out  AWIDTH; req_write_addr_valid  out  1; req_write_addr_ready  in  1.
- req_write_len  out  32  write burst length in words.
- req_write_data  out  DWIDTH; req_write_data_valid  out  1; req_write_data_ready  in  1.
- resp_write_status  out  1  tied 0.
- resp_write_status_valid  out  1  tied 0.
- resp_write_status_ready  in  1  ignored.

Behaviour:
- Reset (async): state IDLE, idle=1, done=0, all valid/ready outputs 0, address/len/data outputs 0, accumulators cleared. Reset mid-run abandons all bursts immediately.
- Handshake: a transfer occurs on a rising edge with valid&ready both high. Valid and its payload are held stable until accepted. Only one read burst is outstanding at a time.
  - resp_read_data_ready is high only while beats of the current burst remain; the engine accepts exactly req_read_len beats.
- Start: when start=1 in IDLE, latch fm_dim and the three offsets, clear done, drop idle the next cycle. start while busy is ignored. fm_dim=0 goes straight to DONE.
- Function, for each output pixel (y,x), 0<=y,x<N:
  - out[y][x] = sum over m,n of ifm[y-H+m][x-H+n] * wt[m][n].
  - Out-of-range IFM taps count as 0.
  - Unsigned products and sums, truncated to DWIDTH bits (wrap modulo 2^DWIDTH).
- Addressing:
  - wt[m][n] at wt_offset + m*WT_DIM + n.
  - ifm[r][c] at ifm_offset + r*N + c.
  - out[y][x] at ofm_offset + y*N + x.
  - All addresses truncated to AWIDTH bits.
- FSM:
  - IDLE -> LOAD_WT: one read burst of WT_DIM*WT_DIM words into a local kernel register file.
  - LOAD_WT -> RD_ADDR / RD_DATA: per pixel, for each kernel row m with a valid IFM row, one burst covering only the valid columns [max(0,x-H), min(N-1,x+H)]; multiply-accumulate each beat against the matching weight. Invalid rows issue no request.
  - -> WR: after all rows, issue write address (len=1) and write data carrying the accumulator. The two channels are independent and either may be accepted first. Advance only after both are accepted.
  - -> next pixel in raster order (x fastest), or DONE after the last pixel.
  - DONE: done=1, idle=1, return to IDLE. done stays high until the next accepted start or reset.
- The write-data handshake is the commit point. done rises no earlier than the cycle after the last write-data handshake.
- Kernel weights are reloaded on every run.

Optional Feature:
- Macro CONV2D_CYCLE_COUNT_EN.
- Defined: adds output cycle_count [31:0]. Cleared on accepted start; increments every cycle while not idle; holds its value in DONE/IDLE; reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- N=4, WT_DIM=3, wt at 0, ifm at 9, ofm at 25; ifm[y][x]=x, wt[m][n]=n -> OFM rows [4,10,16,6], [6,15,24,9], [6,15,24,9], [4,10,16,6]; done=1, idle=1.
- Rerun the same job after done without reset -> done drops after start, then the identical OFM is produced again.
- Controller IO latency 10 with intermittent ready deassertion -> valids and payloads held stable, no lost or duplicate beats, same OFM.
- N=1, ifm=7, all weights 2 -> single output 14; exactly 1 write, read bursts of len 1 only.
- start pulsed mid-run -> ignored, result unchanged. Assert rst mid-run -> idle=1, done=0, all valids 0 immediately; a subsequent start completes correctly.
- With CONV2D_CYCLE_COUNT_EN, weights 0xFFFFFFFF and ifm 2 -> outputs wrap modulo 2^32; cycle_count nonzero and frozen after done.
